// File: rtl/ctrl_50mhz.sv
// 50 MHz write-side controller: deserializes a gated MSB-first bit stream,
// frames packets on a header byte and pushes payload bytes into the async FIFO.
module ctrl_50mhz #(
  parameter logic [7:0] HDR_A = 8'hA5,
  parameter logic [7:0] HDR_B = 8'hC3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       serial_data,
  input  logic       data_ena,
  input  logic       fifo_full,
  output logic       fifo_wr,
  output logic [7:0] fifo_data,
  output logic       overflow,
  output logic       pkt_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HDR  = 2'd1,
    DATA = 2'd2,
    DROP = 2'd3
  } state_t;

  state_t     state;
  logic [2:0] bit_cnt;
  logic [7:0] shift_reg;
  logic [7:0] byte_in;
  logic       byte_done;

  // byte_in is the complete byte on the cycle its 8th bit is on serial_data.
  assign byte_in   = {shift_reg[6:0], serial_data};
  assign byte_done = data_ena && (bit_cnt == 3'd7);

  // FIFO write protocol: fifo_wr is a single-cycle strobe with fifo_data valid
  // in the same cycle; fifo_full is sampled on the byte_done cycle and a byte
  // that meets a full FIFO is dropped and recorded in the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      bit_cnt   <= 3'd0;
      shift_reg <= 8'd0;
      fifo_wr   <= 1'b0;
      fifo_data <= 8'd0;
      overflow  <= 1'b0;
      pkt_err   <= 1'b0;
    end else begin
      fifo_wr <= 1'b0;
      pkt_err <= 1'b0;
      case (state)
        IDLE: begin
          if (data_ena) begin
            shift_reg <= byte_in;
            bit_cnt   <= bit_cnt + 3'd1;
            state     <= HDR;
          end
        end
        HDR: begin
          if (data_ena) begin
            shift_reg <= byte_in;
            bit_cnt   <= bit_cnt + 3'd1;
            if (byte_done) begin
              if ((byte_in == HDR_A) || (byte_in == HDR_B)) begin
                state <= DATA;
              end else begin
                state   <= DROP;
                pkt_err <= 1'b1;
              end
            end
          end else begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
            pkt_err <= 1'b1;
          end
        end
        DATA: begin
          if (data_ena) begin
            shift_reg <= byte_in;
            bit_cnt   <= bit_cnt + 3'd1;
            if (byte_done) begin
              if (!fifo_full) begin
                fifo_wr   <= 1'b1;
                fifo_data <= byte_in;
              end else begin
                overflow <= 1'b1;
              end
            end
          end else begin
            // A non-zero count here means the packet ended mid-byte.
            state   <= IDLE;
            bit_cnt <= 3'd0;
            pkt_err <= (bit_cnt != 3'd0);
          end
        end
        DROP: begin
          if (!data_ena) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
          end
        end
        default: begin
          state   <= IDLE;
          bit_cnt <= 3'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ctrl_50mhz.sv
// Directed bench for ctrl_50mhz: drives packets bit by bit and checks every
// output after each clock edge against hand-computed expectations.
module tb_ctrl_50mhz;

  logic       clk;
  logic       reset;
  logic       serial_data;
  logic       data_ena;
  logic       fifo_full;
  logic       fifo_wr;
  logic [7:0] fifo_data;
  logic       overflow;
  logic       pkt_err;

  int tests_run = 0;
  int tests_failed = 0;

  logic [7:0] exp_data = 8'h00;
  logic       exp_ovf  = 1'b0;

  ctrl_50mhz dut (
    .clk         (clk),
    .reset       (reset),
    .serial_data (serial_data),
    .data_ena    (data_ena),
    .fifo_full   (fifo_full),
    .fifo_wr     (fifo_wr),
    .fifo_data   (fifo_data),
    .overflow    (overflow),
    .pkt_err     (pkt_err)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_outputs(input logic wr, input logic err);
    check("fifo_wr", {7'd0, fifo_wr}, {7'd0, wr});
    check("pkt_err", {7'd0, pkt_err}, {7'd0, err});
    check("fifo_data", fifo_data, exp_data);
    check("overflow", {7'd0, overflow}, {7'd0, exp_ovf});
  endtask

  // Sends the top n bits of b MSB first; wr/err are the expected strobes after
  // the last bit, full_last asserts fifo_full only on the last bit.
  task automatic send_bits(input logic [7:0] b, input int n, input logic wr,
                           input logic err, input logic full_last);
    for (int i = 0; i < n; i++) begin
      logic last;
      last        = (i == n - 1);
      data_ena    = 1'b1;
      serial_data = b[7 - i];
      fifo_full   = last ? full_last : 1'b0;
      @(posedge clk);
      #1;
      if (last && wr) exp_data = b;
      if (last && full_last) exp_ovf = 1'b1;
      check_outputs(last && wr, last && err);
    end
    fifo_full = 1'b0;
  endtask

  task automatic send_hdr(input logic [7:0] b);
    send_bits(b, 8, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic send_data(input logic [7:0] b);
    send_bits(b, 8, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle_cycle(input logic err);
    data_ena    = 1'b0;
    serial_data = 1'b0;
    @(posedge clk);
    #1;
    check_outputs(1'b0, err);
  endtask

  initial begin
    reset       = 1'b1;
    serial_data = 1'b0;
    data_ena    = 1'b0;
    fifo_full   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_outputs(1'b0, 1'b0);
    reset = 1'b0;
    idle_cycle(1'b0);

    // Basic packet, four payload bytes back-to-back
    send_hdr(8'hA5);
    send_data(8'h01);
    send_data(8'h7F);
    send_data(8'h80);
    send_data(8'hFF);
    idle_cycle(1'b0);

    // Bad header: error after 8th bit, remaining bytes ignored
    send_bits(8'h12, 8, 1'b0, 1'b1, 1'b0);
    send_hdr(8'hA5);
    send_hdr(8'h55);
    send_hdr(8'hC3);
    idle_cycle(1'b0);
    send_hdr(8'hC3);
    send_data(8'h55);
    idle_cycle(1'b0);

    // Header cut short: error one cycle after data_ena falls
    send_bits(8'hA5, 4, 1'b0, 1'b0, 1'b0);
    idle_cycle(1'b1);
    idle_cycle(1'b0);

    // FIFO full on the second payload byte: lost, overflow goes sticky
    send_hdr(8'hA5);
    send_data(8'h11);
    send_bits(8'h22, 8, 1'b0, 1'b0, 1'b1);
    send_data(8'h33);
    idle_cycle(1'b0);

    // Partial trailing byte, then a new packet right after
    send_hdr(8'hA5);
    send_data(8'hAA);
    send_bits(8'hE0, 3, 1'b0, 1'b0, 1'b0);
    idle_cycle(1'b1);
    send_hdr(8'hA5);
    send_data(8'h0F);
    idle_cycle(1'b0);

    // Header values inside payload are ordinary data
    send_hdr(8'hA5);
    send_data(8'hC3);
    send_data(8'hA5);
    idle_cycle(1'b0);

    // Reset in the middle of the second payload byte
    send_hdr(8'hA5);
    send_data(8'h11);
    send_bits(8'h22, 4, 1'b0, 1'b0, 1'b0);
    reset       = 1'b1;
    data_ena    = 1'b1;
    serial_data = 1'b0;
    @(posedge clk);
    #1;
    exp_data = 8'h00;
    exp_ovf  = 1'b0;
    check_outputs(1'b0, 1'b0);
    reset = 1'b0;
    idle_cycle(1'b0);
    send_hdr(8'hC3);
    send_data(8'h3C);
    send_data(8'h96);
    idle_cycle(1'b0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
